// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
// Main control unit for a multicycle MIPS datapath. A Moore FSM takes each
// instruction through 3-5 states and drives every mux select and write enable.
// Memory-gated strobes (irwrite/pcwrite in FETCH, memwrite in MEMWR) also
// require mem_ready. The debug outputs are the FSM state, a retired-instruction
// counter and a sticky illegal-opcode/funct flag.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   op, funct    in   instr[31:26] / instr[5:0] from the instruction register
//   zero         in   ALU zero flag (used for beq)
//   mem_ready    in   memory completes the current access this cycle
//   iord         out  memory address select (0 PC, 1 ALUOut)
//   irwrite      out  instruction register load enable
//   memwrite     out  data memory write strobe
//   regwrite     out  register file write enable
//   regdst       out  write address select (0 rt, 1 rd)
//   memtoreg     out  write data select (0 ALUOut, 1 Data register)
//   alusrca      out  ALU A select (0 PC, 1 rs)
//   alusrcb      out  ALU B select (00 rt, 01 4, 10 signimm, 11 signimm<<2)
//   pcsrc        out  next PC select (00 ALUResult, 01 ALUOut, 10 jump target)
//   alucontrol   out  ALU function code
//   pcen         out  PC enable = pcwrite | (branch & zero)
//   state_DBG    out  current FSM state encoding
//   instr_count  out  retired-instruction counter (wraps)
//   illegal_op   out  sticky unsupported-opcode/funct flag
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             iord,
    output logic             irwrite,
    output logic             memwrite,
    output logic             regwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic [2:0]       alucontrol,
    output logic             pcen,
    output logic [3:0]       state_DBG,
    output logic [CNT_W-1:0] instr_count,
    output logic             illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t           r_state;
    state_t           w_next;
    logic             w_pcwrite;
    logic             w_branch;
    logic             w_irwrite;
    logic             w_memwrite;
    logic             w_regwrite;
    logic             w_bad_op;
    logic             w_bad_funct;
    logic             w_retire;
    logic [2:0]       w_funct_alu;
    logic             r_illegal;
    logic [CNT_W-1:0] r_count;

    // R-type funct decode; unknown codes fall back to add and are flagged.
    always_comb begin
        w_bad_funct = 1'b0;
        unique case (funct)
            6'b100000: w_funct_alu = ALU_ADD;
            6'b100010: w_funct_alu = ALU_SUB;
            6'b100100: w_funct_alu = ALU_AND;
            6'b100101: w_funct_alu = ALU_OR;
            6'b101010: w_funct_alu = ALU_SLT;
            default: begin
                w_funct_alu = ALU_ADD;
                w_bad_funct = 1'b1;
            end
        endcase
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next   = S_FETCH;
        w_bad_op = 1'b0;
        case (r_state)
            S_FETCH:   w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default: begin
                        w_next   = S_FETCH;
                        w_bad_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  w_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   w_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: w_next = S_ALUWB;
            S_ADDIEX:  w_next = S_ADDIWB;
            // Write-back/branch/jump states and unreachable codes 12-15 return
            // to FETCH through the default above.
            default:   w_next = S_FETCH;
        endcase
    end

    // Moore output decode.
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        iord       = 1'b0;
        w_irwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = ALU_AND;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        case (r_state)
            S_FETCH: begin
                alusrcb    = 2'b01;
                alucontrol = ALU_ADD;
                w_irwrite  = mem_ready;
                w_pcwrite  = mem_ready;
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg   = 1'b1;
                w_regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                w_memwrite = mem_ready;
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                alucontrol = w_funct_alu;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                w_regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                w_branch   = 1'b1;
                pcsrc      = 2'b01;
            end
            S_ADDIWB: w_regwrite = 1'b1;
            S_JUMP: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Write strobes are gated by reset itself so they drop the instant reset
    // asserts, independent of mem_ready or the flop update.
    assign irwrite  = w_irwrite  & reset;
    assign memwrite = w_memwrite & reset;
    assign regwrite = w_regwrite & reset;
    assign pcen     = (w_pcwrite | (w_branch & zero)) & reset;

    // An instruction retires on the edge that leaves its final state.
    always_comb begin
        case (r_state)
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: w_retire = 1'b1;
            S_MEMWR: w_retire = mem_ready;
            default: w_retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count   <= '0;
            r_illegal <= 1'b0;
        end else begin
            if (w_retire) r_count <= r_count + 1'b1;
            if ((r_state == S_DECODE && w_bad_op) ||
                (r_state == S_EXECUTE && w_bad_funct))
                r_illegal <= 1'b1;
        end
    end

    assign state_DBG   = r_state;
    assign instr_count = r_count;
    assign illegal_op  = r_illegal;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
// Directed, self-checking bench for mips_multicycle_ctrl. Inputs change and
// outputs are sampled on the falling clock edge; expected values are written
// out by hand from the instruction state sequences.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0]  alusrcb, pcsrc;
    logic [2:0]  alucontrol;
    logic        pcen;
    logic [3:0]  state_DBG;
    logic [31:0] instr_count;
    logic        illegal_op;

    int n_cmp = 0;
    int n_bad = 0;

    mips_multicycle_ctrl #(.CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .iord       (iord),
        .irwrite    (irwrite),
        .memwrite   (memwrite),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .pcen       (pcen),
        .state_DBG  (state_DBG),
        .instr_count(instr_count),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one full cycle, ending on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    int cyc, fw, rw, irw0;
    bit left;

    initial begin
        reset = 1'b0; op = 6'd0; funct = 6'b100000; zero = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        // Reset state, with mem_ready high to show strobes stay forced low.
        check("rst_state", state_DBG, 0);
        check("rst_count", instr_count, 0);
        check("rst_illegal", illegal_op, 0);
        check("rst_irwrite", irwrite, 0);
        check("rst_pcen", pcen, 0);
        reset = 1'b1;
        #1;

        // R-type add: 0,1,6,7,0
        check("add_fetch_state", state_DBG, 0);
        check("add_fetch_irwrite", irwrite, 1);
        check("add_fetch_pcen", pcen, 1);
        check("add_fetch_alusrcb", alusrcb, 1);
        step();
        check("add_decode_state", state_DBG, 1);
        check("add_decode_alusrcb", alusrcb, 3);
        check("add_decode_regwrite", regwrite, 0);
        step();
        check("add_exec_state", state_DBG, 6);
        check("add_exec_alu", alucontrol, 3'b010);
        check("add_exec_alusrca", alusrca, 1);
        check("add_exec_regwrite", regwrite, 0);
        step();
        check("add_wb_state", state_DBG, 7);
        check("add_wb_regwrite", regwrite, 1);
        check("add_wb_regdst", regdst, 1);
        check("add_wb_count", instr_count, 0);
        step();
        check("add_done_state", state_DBG, 0);
        check("add_done_count", instr_count, 1);

        // lw with 2 stall cycles in FETCH and 3 in MEMRD: 10 cycles total.
        op = 6'b100011;
        cyc = 0; fw = 0; rw = 0; irw0 = 0; left = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (state_DBG == 0 && fw < 2) begin
                mem_ready = 1'b0; fw++;
            end else if (state_DBG == 3 && rw < 3) begin
                mem_ready = 1'b0; rw++;
            end else begin
                mem_ready = 1'b1;
            end
            #1;
            if (state_DBG == 0 && irwrite == 1'b0) irw0++;
            if (state_DBG == 2) check("lw_memadr_alusrcb", alusrcb, 2);
            if (state_DBG == 3) check("lw_memrd_iord", iord, 1);
            if (state_DBG == 4) begin
                check("lw_memwb_memtoreg", memtoreg, 1);
                check("lw_memwb_regwrite", regwrite, 1);
            end
            step();
            cyc++;
            if (state_DBG != 0) left = 1'b1;
            if (left && state_DBG == 0) break;
        end
        check("lw_cycles", cyc, 10);
        check("lw_fetch_stalls", irw0, 2);
        check("lw_count", instr_count, 2);
        mem_ready = 1'b1;

        // beq taken, then not taken.
        op = 6'b000100; zero = 1'b1;
        step(); step();
        check("beq1_state", state_DBG, 8);
        check("beq1_alu", alucontrol, 3'b110);
        check("beq1_pcsrc", pcsrc, 1);
        check("beq1_pcen", pcen, 1);
        step();
        zero = 1'b0;
        step(); step();
        check("beq0_state", state_DBG, 8);
        check("beq0_pcen", pcen, 0);
        step();
        check("beq_count", instr_count, 4);

        // sw with one wait cycle in MEMWR, then j.
        op = 6'b101011;
        step(); step(); step();
        check("sw_state", state_DBG, 5);
        mem_ready = 1'b0;
        #1;
        check("sw_wait_memwrite", memwrite, 0);
        check("sw_wait_iord", iord, 1);
        step();
        mem_ready = 1'b1;
        #1;
        check("sw_hold_state", state_DBG, 5);
        check("sw_memwrite", memwrite, 1);
        step();
        check("sw_after_memwrite", memwrite, 0);
        check("sw_after_state", state_DBG, 0);
        op = 6'b000010;
        step(); step();
        check("j_state", state_DBG, 11);
        check("j_pcsrc", pcsrc, 2);
        check("j_pcen", pcen, 1);
        step();
        check("swj_count", instr_count, 6);

        // Illegal op, then addi: flag is sticky, count skips the illegal op.
        op = 6'b111111;
        step();
        check("ill_decode_flag", illegal_op, 0);
        step();
        check("ill_state", state_DBG, 0);
        check("ill_flag", illegal_op, 1);
        check("ill_count", instr_count, 6);
        op = 6'b001000;
        step(); step();
        check("addi_ex_state", state_DBG, 9);
        check("addi_ex_alusrcb", alusrcb, 2);
        step();
        check("addi_wb_state", state_DBG, 10);
        check("addi_wb_regwrite", regwrite, 1);
        check("addi_wb_regdst", regdst, 0);
        step();
        check("addi_count", instr_count, 7);
        check("addi_flag", illegal_op, 1);

        // Reset in the middle of a ready MEMWR cycle.
        op = 6'b101011;
        step(); step(); step();
        check("rst_sw_memwrite", memwrite, 1);
        #2;
        reset = 1'b0;
        #1;
        check("rstmid_memwrite", memwrite, 0);
        check("rstmid_state", state_DBG, 0);
        check("rstmid_count", instr_count, 0);
        check("rstmid_illegal", illegal_op, 0);
        check("rstmid_pcen", pcen, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
